// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one Wishbone-style memory port between I-fetch and the MEM stage
//
// Purpose: serialises instruction fetches and data accesses onto a single bus
// master port. Each access runs IDLE -> BUSY -> DONE. The stall requests keep
// the pipeline frozen until the data returns. A result is held while the
// consuming stage is stalled, and it is dropped if a flush arrives.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_stall[5:0]        stall vector from ctrl (bit 1 = IF held, bit 4 = MEM held)
//   i_flush             pipeline flush
//   i_if_ce/i_if_addr   I-side read request; o_if_data / o_stallreq_if back
//   i_mem_*             D-side request; o_mem_rdata / o_stallreq_mem back
//   o_bus_*             registered bus cycle, strobe, write enable, selects, address, data
//   i_bus_dat_i/i_bus_ack  bus read data and acknowledge
//   o_arb_err           one-cycle pulse when the bus watchdog expires
//
// Build option: define ARB_TIMEOUT_EN to enable the bus watchdog. The watchdog
// aborts a BUSY cycle after TIMEOUT_CYCLES cycles without an ack.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_stall,
    input  logic        i_flush,
    input  logic        i_if_ce,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_data,
    output logic        o_stallreq_if,
    input  logic        i_mem_ce,
    input  logic        i_mem_we,
    input  logic [3:0]  i_mem_sel,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_stallreq_mem,
    output logic        o_bus_cyc,
    output logic        o_bus_stb,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_adr,
    output logic [31:0] o_bus_dat_o,
    input  logic [31:0] i_bus_dat_i,
    input  logic        i_bus_ack,
    output logic        o_arb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner_d;     // 1: D-side owns the current access, 0: I-side
    logic        r_discard;     // a flush hit while BUSY, so the result must not be delivered
    logic        r_bus_cyc;
    logic        r_bus_stb;
    logic        r_bus_we;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_adr;
    logic [31:0] r_bus_dat_o;
    // The read buffer is kept per consumer. Each data output then holds its
    // last delivered value, and a discarded access never disturbs it.
    logic [31:0] r_if_data;
    logic [31:0] r_mem_rdata;

    logic        w_drop;
    logic        w_owner_hold;
    logic        w_done_i;
    logic        w_done_d;
    logic        w_expire;
    logic [31:0] w_result;
    logic        w_unused;

    assign w_drop       = r_discard | i_flush;
    assign w_owner_hold = r_owner_d ? i_stall[4] : i_stall[1];
    assign w_done_d     = (r_state == S_DONE) &  r_owner_d;
    assign w_done_i     = (r_state == S_DONE) & ~r_owner_d;
    // A watchdog expiry delivers zero. An ack in the same cycle still wins.
    assign w_result     = i_bus_ack ? i_bus_dat_i : 32'h0;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_cnt;
    logic        r_arb_err;
    // r_cnt counts the earlier no-ack BUSY cycles. This cycle is therefore the
    // TIMEOUT_CYCLES-th one without an ack.
    assign w_expire  = ~i_bus_ack & (r_cnt == TO_LAST);
    assign o_arb_err = r_arb_err;
    assign w_unused  = ^{i_stall[5], i_stall[3:2], i_stall[0]};
`else
    assign w_expire  = 1'b0;
    assign o_arb_err = 1'b0;
    assign w_unused  = ^{i_stall[5], i_stall[3:2], i_stall[0], (TIMEOUT_CYCLES != 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_discard   <= 1'b0;
            r_bus_cyc   <= 1'b0;
            r_bus_stb   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'h0;
            r_bus_adr   <= 32'h0;
            r_bus_dat_o <= 32'h0;
            r_if_data   <= 32'h0;
            r_mem_rdata <= 32'h0;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= 16'd0;
            r_arb_err   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_arb_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_discard <= 1'b0;
                    if (!i_flush && (i_mem_ce || i_if_ce)) begin
                        r_state   <= S_BUSY;
                        r_bus_cyc <= 1'b1;
                        r_bus_stb <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= 16'd0;
`endif
                        // D wins because MEM holds the older instruction.
                        if (i_mem_ce) begin
                            r_owner_d   <= 1'b1;
                            r_bus_we    <= i_mem_we;
                            r_bus_sel   <= i_mem_sel;
                            r_bus_adr   <= i_mem_addr;
                            r_bus_dat_o <= i_mem_wdata;
                        end else begin
                            r_owner_d   <= 1'b0;
                            r_bus_we    <= 1'b0;
                            r_bus_sel   <= 4'hF;
                            r_bus_adr   <= i_if_addr;
                        end
                    end
                end
                S_BUSY: begin
                    if (i_bus_ack || w_expire) begin
                        r_bus_cyc <= 1'b0;
                        r_bus_stb <= 1'b0;
                        r_bus_we  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        r_arb_err <= w_expire;
`endif
                        if (w_drop) begin
                            r_state   <= S_IDLE;
                            r_discard <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            if (r_owner_d) begin
                                r_mem_rdata <= w_result;
                            end else begin
                                r_if_data   <= w_result;
                            end
                        end
                    end else begin
                        // The bus cycle is never abandoned. A flush only marks it for discard.
                        if (i_flush) begin
                            r_discard <= 1'b1;
                        end
`ifdef ARB_TIMEOUT_EN
                        r_cnt <= r_cnt + 16'd1;
`endif
                    end
                end
                S_DONE: begin
                    if (i_flush || !w_owner_hold) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stallreq_if  = ~rst & i_if_ce  & ~i_flush & ~w_done_i;
    assign o_stallreq_mem = ~rst & i_mem_ce & ~i_flush & ~w_done_d;

    assign o_if_data   = r_if_data;
    assign o_mem_rdata = r_mem_rdata;
    assign o_bus_cyc   = r_bus_cyc;
    assign o_bus_stb   = r_bus_stb;
    assign o_bus_we    = r_bus_we;
    assign o_bus_sel   = r_bus_sel;
    assign o_bus_adr   = r_bus_adr;
    assign o_bus_dat_o = r_bus_dat_o;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        flush = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] bus_dat_i = 32'h0;
    logic        bus_ack = 1'b0;

    logic [31:0] o_if_data, o_mem_rdata, o_bus_adr, o_bus_dat_o;
    logic        o_stallreq_if, o_stallreq_mem, o_bus_cyc, o_bus_stb, o_bus_we, o_arb_err;
    logic [3:0]  o_bus_sel;

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
        .i_if_ce(if_ce), .i_if_addr(if_addr), .o_if_data(o_if_data), .o_stallreq_if(o_stallreq_if),
        .i_mem_ce(mem_ce), .i_mem_we(mem_we), .i_mem_sel(mem_sel), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .o_mem_rdata(o_mem_rdata), .o_stallreq_mem(o_stallreq_mem),
        .o_bus_cyc(o_bus_cyc), .o_bus_stb(o_bus_stb), .o_bus_we(o_bus_we), .o_bus_sel(o_bus_sel),
        .o_bus_adr(o_bus_adr), .o_bus_dat_o(o_bus_dat_o), .i_bus_dat_i(bus_dat_i),
        .i_bus_ack(bus_ack), .o_arb_err(o_arb_err)
    );

    always #5 clk = ~clk;

    // Staged stimulus, applied at the next falling edge
    logic        n_rst, n_flush, n_if_ce, n_mem_ce, n_mem_we, n_ack;
    logic [5:0]  n_stall;
    logic [3:0]  n_mem_sel;
    logic [31:0] n_if_addr, n_mem_addr, n_mem_wdata, n_dat_i;

    // Transaction-level model state
    bit          m_busy, m_dropped, m_is_d, m_has_result, m_res_d, m_cyc, m_we, m_err;
    int          m_waited;
    logic [3:0]  m_sel = 4'h0;
    logic [31:0] m_adr = 32'h0, m_wdata = 32'h0, m_if_data = 32'h0, m_mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic e_sr_if, e_sr_mem;
        e_sr_if  = !rst && if_ce  && !flush && !(m_has_result && !m_res_d);
        e_sr_mem = !rst && mem_ce && !flush && !(m_has_result &&  m_res_d);
        chk1("stallreq_if", o_stallreq_if, e_sr_if);
        chk1("stallreq_mem", o_stallreq_mem, e_sr_mem);
        chk1("bus_cyc", o_bus_cyc, m_cyc);
        chk1("bus_stb", o_bus_stb, m_cyc);
        chk1("bus_we", o_bus_we, m_we);
        chk1("arb_err", o_arb_err, m_err);
        chk32("if_data", o_if_data, m_if_data);
        chk32("mem_rdata", o_mem_rdata, m_mem_rdata);
        if (m_cyc) begin
            chk32("bus_adr", o_bus_adr, m_adr);
            chk32("bus_sel", {28'd0, o_bus_sel}, {28'd0, m_sel});
            if (m_we) chk32("bus_dat_o", o_bus_dat_o, m_wdata);
        end
    endtask

    // Advance the model by one clock, using the inputs that are applied now
    task automatic model_step();
        bit          expire;
        logic [31:0] res;
        m_err  = 0;
        expire = 0;
        if (rst) begin
            m_busy = 0; m_dropped = 0; m_has_result = 0; m_cyc = 0; m_we = 0;
            m_sel = 4'h0; m_adr = 32'h0; m_wdata = 32'h0; m_if_data = 32'h0; m_mem_rdata = 32'h0;
            return;
        end
        if (m_busy) begin
            if (!bus_ack) begin
                m_waited++;
`ifdef ARB_TIMEOUT_EN
                expire = (m_waited == TO);
`endif
                if (flush) m_dropped = 1;
            end
            if (bus_ack || expire) begin
                res    = bus_ack ? bus_dat_i : 32'h0;
                m_busy = 0; m_cyc = 0; m_we = 0; m_err = expire;
                if (!m_dropped && !flush) begin
                    m_has_result = 1;
                    m_res_d      = m_is_d;
                    if (m_is_d) m_mem_rdata = res;
                    else        m_if_data   = res;
                end
                m_dropped = 0;
            end
        end else if (m_has_result) begin
            if (flush || !(m_res_d ? stall[4] : stall[1])) m_has_result = 0;
        end else if (!flush && (mem_ce || if_ce)) begin
            m_busy = 1; m_cyc = 1; m_waited = 0; m_dropped = 0; m_is_d = mem_ce;
            m_we  = mem_ce ? mem_we : 1'b0;
            m_sel = mem_ce ? mem_sel : 4'hF;
            m_adr = mem_ce ? mem_addr : if_addr;
            if (mem_ce) m_wdata = mem_wdata;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rst = n_rst; stall = n_stall; flush = n_flush;
        if_ce = n_if_ce; if_addr = n_if_addr;
        mem_ce = n_mem_ce; mem_we = n_mem_we; mem_sel = n_mem_sel;
        mem_addr = n_mem_addr; mem_wdata = n_mem_wdata;
        bus_ack = n_ack; bus_dat_i = n_dat_i;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic idle_inputs();
        n_rst = 0; n_stall = 6'd0; n_flush = 0; n_if_ce = 0; n_mem_ce = 0; n_mem_we = 0;
        n_mem_sel = 4'h0; n_ack = 0; n_dat_i = 32'h0;
        n_if_addr = 32'h0; n_mem_addr = 32'h0; n_mem_wdata = 32'h0;
    endtask

    task automatic drain();
        n_if_ce = 0; n_mem_ce = 0; n_flush = 0; n_stall = 6'd0; n_rst = 0;
        for (int i = 0; i < 8; i++) begin
            n_ack = m_busy;
            tick();
        end
        n_ack = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual still running required finished at %0t", $time);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);

        // Reset: the stall requests are masked even with both requests up
        n_rst = 1; n_if_ce = 1; n_mem_ce = 1;
        tick();
        chk1("rst_stallreq_if", o_stallreq_if, 1'b0);
        chk1("rst_stallreq_mem", o_stallreq_mem, 1'b0);
        chk1("rst_bus_cyc", o_bus_cyc, 1'b0);
        chk32("rst_bus_adr", o_bus_adr, 32'h0);
        chk32("rst_if_data", o_if_data, 32'h0);
        chk32("rst_mem_rdata", o_mem_rdata, 32'h0);

        // I-fetch with ack in cycle 1
        idle_inputs(); n_if_ce = 1; n_if_addr = 32'h100;
        tick(); chk1("t1_c0_sr_if", o_stallreq_if, 1'b1);
        n_ack = 1; n_dat_i = 32'h3C010001;
        tick(); chk1("t1_c1_sr_if", o_stallreq_if, 1'b1); chk1("t1_c1_cyc", o_bus_cyc, 1'b1);
        chk32("t1_c1_adr", o_bus_adr, 32'h100); chk32("t1_c1_sel", {28'd0, o_bus_sel}, 32'hF);
        chk1("t1_c1_we", o_bus_we, 1'b0);
        n_ack = 0;
        tick(); chk1("t1_c2_sr_if", o_stallreq_if, 1'b0); chk32("t1_c2_if_data", o_if_data, 32'h3C010001);
        chk1("t1_c2_cyc", o_bus_cyc, 1'b0);
        drain();

        // Byte-select store
        idle_inputs(); n_mem_ce = 1; n_mem_we = 1; n_mem_sel = 4'b0011;
        n_mem_addr = 32'h80; n_mem_wdata = 32'hDEADBEEF;
        tick();
        tick(); chk1("t2_c1_we", o_bus_we, 1'b1); chk32("t2_c1_sel", {28'd0, o_bus_sel}, 32'h3);
        chk32("t2_c1_adr", o_bus_adr, 32'h80); chk32("t2_c1_dat_o", o_bus_dat_o, 32'hDEADBEEF);
        chk1("t2_c1_sr_mem", o_stallreq_mem, 1'b1);
        n_ack = 1;
        tick(); chk1("t2_c2_cyc", o_bus_cyc, 1'b1); chk32("t2_c2_dat_o", o_bus_dat_o, 32'hDEADBEEF);
        n_ack = 0;
        tick(); chk1("t2_c3_sr_mem", o_stallreq_mem, 1'b0); chk1("t2_c3_we", o_bus_we, 1'b0);
        tick(); chk1("t2_c4_sr_mem", o_stallreq_mem, 1'b1);
        drain();

        // Simultaneous requests: D first, then I after one IDLE cycle
        idle_inputs(); n_mem_ce = 1; n_mem_addr = 32'h200; n_if_ce = 1; n_if_addr = 32'h300;
        tick(); chk1("t3_c0_sr_if", o_stallreq_if, 1'b1); chk1("t3_c0_sr_mem", o_stallreq_mem, 1'b1);
        n_ack = 1; n_dat_i = 32'h11111111;
        tick(); chk32("t3_c1_adr", o_bus_adr, 32'h200); chk1("t3_c1_sr_if", o_stallreq_if, 1'b1);
        n_ack = 0;
        tick(); chk1("t3_c2_sr_mem", o_stallreq_mem, 1'b0); chk1("t3_c2_sr_if", o_stallreq_if, 1'b1);
        chk32("t3_c2_mem_rdata", o_mem_rdata, 32'h11111111);
        n_mem_ce = 0;
        tick(); chk1("t3_c3_cyc", o_bus_cyc, 1'b0); chk1("t3_c3_sr_if", o_stallreq_if, 1'b1);
        n_ack = 1; n_dat_i = 32'h22222222;
        tick(); chk1("t3_c4_cyc", o_bus_cyc, 1'b1); chk32("t3_c4_adr", o_bus_adr, 32'h300);
        chk1("t3_c4_sr_if", o_stallreq_if, 1'b1);
        n_ack = 0;
        tick(); chk1("t3_c5_sr_if", o_stallreq_if, 1'b0); chk32("t3_c5_if_data", o_if_data, 32'h22222222);
        drain();

        // Load held in DONE by stall[4] for 3 cycles
        idle_inputs(); n_mem_ce = 1; n_mem_addr = 32'h40;
        tick();
        n_ack = 1; n_dat_i = 32'hCAFEF00D;
        tick();
        n_ack = 0; n_stall = 6'b010000; n_if_ce = 1; n_if_addr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk32("t4_hold_mem_rdata", o_mem_rdata, 32'hCAFEF00D);
            chk1("t4_hold_sr_mem", o_stallreq_mem, 1'b0);
            chk1("t4_hold_cyc", o_bus_cyc, 1'b0);
        end
        n_stall = 6'd0;
        tick(); chk1("t4_c5_cyc", o_bus_cyc, 1'b0); chk1("t4_c5_sr_mem", o_stallreq_mem, 1'b0);
        n_mem_ce = 0;
        tick();
        drain();

        // Flush during a load: the cycle completes, nothing is delivered
        idle_inputs(); n_mem_ce = 1; n_mem_addr = 32'h44;
        tick();
        n_flush = 1;
        tick(); chk1("t5_c1_cyc", o_bus_cyc, 1'b1); chk1("t5_c1_sr_mem", o_stallreq_mem, 1'b0);
        n_flush = 0; n_mem_ce = 0;
        tick(); chk1("t5_c2_cyc", o_bus_cyc, 1'b1);
        n_ack = 1; n_dat_i = 32'h99999999;
        tick(); chk1("t5_c3_cyc", o_bus_cyc, 1'b1);
        n_ack = 0; n_mem_ce = 1;
        tick(); chk1("t5_c4_cyc", o_bus_cyc, 1'b0); chk1("t5_c4_sr_mem", o_stallreq_mem, 1'b1);
        chk32("t5_c4_mem_rdata", o_mem_rdata, 32'hCAFEF00D);
        drain();

`ifdef ARB_TIMEOUT_EN
        // Slave never acks: the watchdog ends the cycle with zero data
        idle_inputs(); n_mem_ce = 1; n_mem_addr = 32'h48;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick(); chk1("t6_wait_cyc", o_bus_cyc, 1'b1); chk1("t6_wait_err", o_arb_err, 1'b0);
        end
        tick(); chk1("t6_c5_cyc", o_bus_cyc, 1'b0); chk1("t6_c5_err", o_arb_err, 1'b1);
        chk32("t6_c5_mem_rdata", o_mem_rdata, 32'h0); chk1("t6_c5_sr_mem", o_stallreq_mem, 1'b0);
        n_mem_ce = 0;
        tick(); chk1("t6_c6_err", o_arb_err, 1'b0);
        drain();
`endif

        // Reset in the middle of a transaction
        idle_inputs(); n_if_ce = 1; n_if_addr = 32'h600;
        tick();
        tick(); chk1("t7_c1_cyc", o_bus_cyc, 1'b1);
        n_rst = 1;
        tick(); chk1("t7_c2_sr_if", o_stallreq_if, 1'b0); chk1("t7_c2_cyc", o_bus_cyc, 1'b1);
        n_rst = 0;
        tick(); chk1("t7_c3_cyc", o_bus_cyc, 1'b0); chk32("t7_c3_if_data", o_if_data, 32'h0);
        chk1("t7_c3_sr_if", o_stallreq_if, 1'b1);
        drain();

        // Randomised traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            n_rst       = ($urandom_range(0, 199) == 0);
            n_flush     = ($urandom_range(0, 9) == 0);
            n_stall     = 6'($urandom);
            n_if_ce     = 1'($urandom_range(0, 1));
            n_mem_ce    = ($urandom_range(0, 2) == 0);
            n_mem_we    = 1'($urandom_range(0, 1));
            n_mem_sel   = 4'($urandom);
            n_if_addr   = $urandom;
            n_mem_addr  = $urandom;
            n_mem_wdata = $urandom;
            n_dat_i     = $urandom;
            n_ack       = m_busy && ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-master bus arbiter sharing one Wishbone-style memory port between instruction fetch (I-side) and the MEM stage (D-side). It sequences each access through a small FSM and drives `stallreq_if`/`stallreq_mem` into `ctrl` so the pipeline freezes until data returns. When `ctrl` keeps the consuming stage stalled, the arbiter holds the returned result. It aborts delivery on `flush`.

## Interface
- `TIMEOUT_CYCLES`, 255: bus watchdog limit in cycles, range 1..65535; used only with `ARB_TIMEOUT_EN`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 6: stall vector from `ctrl`. Bit 1 = IF held, bit 4 = MEM held.
- `flush` in 1: pipeline flush from `ctrl`.
- `if_ce` in 1: I-side read request.
- `if_addr` in 32: I-side address.
- `if_data` out 32: fetched instruction.
- `stallreq_if` out 1: I-side stall request.
- `mem_ce` in 1: D-side request.
- `mem_we` in 1: D-side write enable.
- `mem_sel` in 4: D-side byte selects.
- `mem_addr` in 32: D-side address.
- `mem_wdata` in 32: D-side store data.
- `mem_rdata` out 32: D-side load data.
- `stallreq_mem` out 1: D-side stall request.
- `bus_cyc`, `bus_stb`, `bus_we` out 1 each: registered bus controls.
- `bus_sel` out 4: registered byte selects.
- `bus_adr` out 32: registered address.
- `bus_dat_o` out 32: registered write data.
- `bus_dat_i` in 32: bus read data.
- `bus_ack` in 1: bus acknowledge.
- `arb_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- State registers:
  - `state` ∈ {IDLE, BUSY, DONE}.
  - `owner` ∈ {I, D}.
  - `discard` flag.
  - `rd_buf[31:0]`.
- IDLE:
  - If `flush` = 1, nothing is issued.
  - Else if `mem_ce` = 1, latch the D-side request into the bus registers and go to BUSY with owner = D. D has priority because MEM holds the older instruction.
  - Else if `if_ce` = 1, do the same with owner = I. For I-side requests `bus_we` = 0 and `bus_sel` = 4'hF.
- BUSY:
  - `bus_cyc` and `bus_stb` stay at 1 until `bus_ack`.
  - On `bus_ack`: `bus_cyc`, `bus_stb` and `bus_we` drop to 0, and `rd_buf` ← `bus_dat_i`.
  - After the ack, go to DONE if `discard` = 0, else go to IDLE.
  - `flush` during BUSY sets `discard`. The bus cycle is never abandoned early.
- DONE:
  - The owner's data output equals `rd_buf`, and the owner's stallreq is 0.
  - If `flush` = 1, go to IDLE and drop the result.
  - Else if the owner's stall bit (`stall[4]` for D, `stall[1]` for I) is 1, remain in DONE and hold the result.
  - Otherwise go to IDLE.
- `stallreq_x` (combinational) = `x_ce` & !`flush` & !(state = DONE & owner = x). This means a non-owner requester is stalled while the bus is busy.
- Writes follow the same path. `mem_rdata` in DONE is don't-care for writes but still equals `rd_buf`.
- `discard` clears on entry to IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - All bus outputs = 0.
  - `if_data` = `mem_rdata` = 0.
  - `rd_buf` = 0.
  - `arb_err` = 0.
  - `discard` = 0.
  - The stallreqs are 0 during reset.
- A reset mid-transaction drops `bus_cyc` on the next edge.
- Access latency:
  - Request seen in IDLE at cycle 0.
  - `bus_cyc` high in cycle 1.
  - Ack in cycle k ≥ 1.
  - DONE in cycle k+1, where stallreq goes low.
  - Minimum access is 3 cycles with 2 stall cycles.
- Simultaneous `mem_ce` and `if_ce` in IDLE: D is served first. I stays stalled and is served after D's DONE→IDLE.
- `bus_ack` coincident with `flush`: the result is discarded and the next state is IDLE.
- Back-to-back accesses always pass through one IDLE cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
- When the count reaches `TIMEOUT_CYCLES`:
  - `bus_cyc` and `bus_stb` drop.
  - `rd_buf` ← 32'h0.
  - `arb_err` pulses high for 1 cycle.
  - The next state is DONE (or IDLE if `discard` = 1).
- Ack in the same cycle as expiry wins: normal completion, no error.
- `ARB_TIMEOUT_EN` undefined: no counter, BUSY waits indefinitely, and `arb_err` is tied to 0.

## Test plan
- I-fetch, `if_addr` = 0x00000100, slave acks in cycle 1 with 0x3C010001 -> `stallreq_if` high in cycles 0–1, low in cycle 2 with `if_data` = 0x3C010001.
- Store with `mem_sel` = 4'b0011, `mem_addr` = 0x80, `mem_wdata` = 0xDEADBEEF -> bus shows `we` = 1, `sel` = 3, `adr` = 0x80, `dat_o` = 0xDEADBEEF until ack, then `stallreq_mem` low for one cycle.
- `if_ce` and `mem_ce` both asserted -> D transaction issued first, I transaction issued after D's DONE plus one IDLE cycle, and `stallreq_if` stays high throughout.
- Load completes with `stall[4]` = 1 for 3 cycles -> state held in DONE, `mem_rdata` stable, no new bus cycle starts.
- `flush` asserted in cycle 1 of a load, ack arrives in cycle 3 -> `bus_cyc` stays high until the ack, no DONE state, and `mem_rdata` is unchanged.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, slave never acks -> `bus_cyc` drops after 4 BUSY cycles, `arb_err` pulses once, `mem_rdata` = 0.
